shift_ext_unit_seq: RTL and testbench

//  Parametrised, multi-cycle successor to the stage-4 shifter/extender datapath of the JALA CPU.
//  - Immediate path: zero- and sign-extends the IR immediate field.
//  - Shift path: iterative shifter moving at most STEP bits per cycle, with Start/Busy/Done handshake.
//  - The control FSM stalls the stage on Busy and samples ShifterOut on Done.

---
 rtl/jala_shift_pkg.sv | 22 ++
 rtl/shift_step.sv | 78 +++++++
 rtl/shift_ext_unit_seq.sv | 153 +++++++++++++++
 tb/tb_shift_ext_unit_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/jala_shift_pkg.sv
// jala_shift_pkg
// Shared encodings for the JALA stage-4 shifter/extender.
//   MODE_LOG / MODE_ARI / MODE_ROT : operation select on the Mode input
//                                    (2'b11 is treated as logical)
//   DIR_LEFT / DIR_RIGHT           : shift direction on the Dir input
//   state_t                        : control FSM states
package jala_shift_pkg;

   localparam logic [1:0] MODE_LOG = 2'b00;
   localparam logic [1:0] MODE_ARI = 2'b01;
   localparam logic [1:0] MODE_ROT = 2'b10;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/shift_step.sv
// shift_step
// Combinational single-step shifter.  It moves a value by 0..STEP bit
// positions in one go.  The iterative top level applies it once per cycle.
// Ports:
//   i_value  [WIDTH]  value to shift
//   i_k      [KW]     shift distance for this step, 0..STEP
//   i_mode   [2]      MODE_LOG / MODE_ARI / MODE_ROT (2'b11 = logical)
//   i_dir    [1]      DIR_LEFT or DIR_RIGHT
//   i_fill   [1]      sign bit to shift in on arithmetic right shifts
//   o_result [WIDTH]  shifted value
// Macro SHIFT_EXT_ROTATE_EN builds the rotate path.  Without it, MODE_ROT
// behaves as a logical shift.
module shift_step
   import jala_shift_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int STEP  = 4,
   localparam int KW    = $clog2(STEP + 1)
)
(
   input  logic [WIDTH-1:0] i_value,
   input  logic [KW-1:0]    i_k,
   input  logic [1:0]       i_mode,
   input  logic             i_dir,
   input  logic             i_fill,
   output logic [WIDTH-1:0] o_result
);

   logic             w_fillBit;
   logic [WIDTH-1:0] w_fillMask;
`ifdef SHIFT_EXT_ROTATE_EN
   logic             w_rotate;
   logic [31:0]      w_backAmt;
`endif

   // Decode the mode into "which bit enters on a right shift".
   // Only arithmetic mode shifts the sign in.  A left shift always
   // brings in zeros, so arithmetic left is the same as logical left.
   always_comb begin
      w_fillBit = 1'b0;
`ifdef SHIFT_EXT_ROTATE_EN
      w_rotate  = 1'b0;
`endif
      case (i_mode)
         MODE_ARI: w_fillBit = i_fill;
`ifdef SHIFT_EXT_ROTATE_EN
         MODE_ROT: w_rotate  = 1'b1;
         MODE_LOG: w_fillBit = 1'b0;
`else
         MODE_LOG, MODE_ROT: w_fillBit = 1'b0;
`endif
         default:  w_fillBit = 1'b0;
      endcase
   end

   // The top i_k bits are the ones vacated by a right shift.  They take
   // the fill bit.  A rotate wraps the bits that fall off.  For k=0 the
   // wrap-around shift is WIDTH, which yields zero, so the value is unchanged.
   always_comb begin
      w_fillMask = ~({WIDTH{1'b1}} >> i_k);
      if (i_dir == DIR_LEFT) begin
         o_result = i_value << i_k;
      end else begin
         o_result = (i_value >> i_k) | (w_fillBit ? w_fillMask : '0);
      end
`ifdef SHIFT_EXT_ROTATE_EN
      w_backAmt = 32'(WIDTH) - 32'(i_k);
      if (w_rotate) begin
         if (i_dir == DIR_LEFT) begin
            o_result = (i_value << i_k) | (i_value >> w_backAmt);
         end else begin
            o_result = (i_value >> i_k) | (i_value << w_backAmt);
         end
      end
`endif
   end

endmodule

// File: rtl/shift_ext_unit_seq.sv
// shift_ext_unit_seq
// Multi-cycle shifter/extender for stage 4 of the JALA CPU.
//   - The immediate path zero- and sign-extends Imm combinationally.
//   - The shift path runs an iterative shifter that moves at most STEP
//     bits per cycle.  It uses a Start/Busy/Done handshake.
// Ports:
//   CLK         in   rising-edge clock
//   RST         in   synchronous active-high reset
//   Start       in   request.  It is sampled only when Busy=0.
//   ShiftIn     in   [WIDTH]      operand
//   Imm         in   [IMM_WIDTH]  immediate.  It is also the shift amount.
//   Mode        in   [2]          00 logical, 01 arithmetic, 10 rotate, 11 logical
//   Dir         in   [1]          0 left, 1 right
//   Busy        out  shift in progress
//   Done        out  one-cycle pulse.  The result is valid from this cycle on.
//   ShifterOut  out  [WIDTH]  result.  It is held until the next accepted Start.
//   ZeroExtOut  out  [WIDTH]  zero-extended Imm
//   SignExtOut  out  [WIDTH]  sign-extended Imm
// Parameters: WIDTH must be a power of two and greater than IMM_WIDTH.
//   STEP must be in 1..WIDTH.
// Macro SHIFT_EXT_ROTATE_EN enables rotate for Mode=10, with the amount
// taken as Imm mod WIDTH.  Without it, Mode=10 is a saturating logical shift.
module shift_ext_unit_seq
   import jala_shift_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int IMM_WIDTH = 12,
   parameter int STEP      = 4
)
(
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 Start,
   input  logic [WIDTH-1:0]     ShiftIn,
   input  logic [IMM_WIDTH-1:0] Imm,
   input  logic [1:0]           Mode,
   input  logic                 Dir,
   output logic                 Busy,
   output logic                 Done,
   output logic [WIDTH-1:0]     ShifterOut,
   output logic [WIDTH-1:0]     ZeroExtOut,
   output logic [WIDTH-1:0]     SignExtOut
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int KW = $clog2(STEP + 1);
   // The amount compare is wide enough to hold both Imm and WIDTH.
   localparam int AW = ((IMM_WIDTH > CW) ? IMM_WIDTH : CW) + 1;

   state_t           r_state;
   state_t           w_nextState;
   logic [WIDTH-1:0] r_work;
   logic [WIDTH-1:0] w_stepOut;
   logic [CW-1:0]    r_rem;
   logic [CW-1:0]    w_remNext;
   logic [CW-1:0]    w_amtEff;
   logic [KW-1:0]    w_k;
   logic [1:0]       r_mode;
   logic             r_dir;
   logic             r_fill;
   logic             w_accept;
   logic [AW-1:0]    w_immWide;

   // Effective amount loaded at acceptance.  Linear shifts saturate at
   // WIDTH, because shifting further cannot change an all-fill result.
   // A rotate only needs the amount modulo WIDTH.
   always_comb begin
      w_immWide = AW'(Imm);
      if (w_immWide >= AW'(WIDTH)) begin
         w_amtEff = CW'(WIDTH);
      end else begin
         w_amtEff = w_immWide[CW-1:0];
      end
`ifdef SHIFT_EXT_ROTATE_EN
      if (Mode == MODE_ROT) begin
         w_amtEff = CW'(w_immWide & AW'(WIDTH - 1));
      end
`endif
   end

   // Per-cycle step size: the remaining distance, capped at STEP.
   always_comb begin
      if (r_rem < CW'(STEP)) begin
         w_k = r_rem[KW-1:0];
      end else begin
         w_k = KW'(STEP);
      end
      w_remNext = r_rem - CW'(w_k);
   end

   shift_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_step (
      .i_value  (r_work),
      .i_k      (w_k),
      .i_mode   (r_mode),
      .i_dir    (r_dir),
      .i_fill   (r_fill),
      .o_result (w_stepOut)
   );

   // A request is taken whenever no shift is in flight.  This includes
   // the DONE cycle, which allows back-to-back operations.
   assign w_accept = Start && (r_state != ST_SHIFT);

   // Next-state logic.  A SHIFT cycle always runs once, even for a zero
   // amount, so Done never coincides with acceptance.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE:  if (Start) w_nextState = ST_SHIFT;
         ST_SHIFT: if (w_remNext == '0) w_nextState = ST_DONE;
         ST_DONE:  w_nextState = Start ? ST_SHIFT : ST_IDLE;
         default:  w_nextState = ST_IDLE;
      endcase
   end

   // State and datapath registers.  The operand, mode, direction and sign
   // bit are captured at acceptance, so later input changes cannot disturb
   // an operation in progress.  The work register moves only in SHIFT.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_IDLE;
         r_work  <= '0;
         r_rem   <= '0;
         r_mode  <= MODE_LOG;
         r_dir   <= DIR_LEFT;
         r_fill  <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (w_accept) begin
            r_work <= ShiftIn;
            r_rem  <= w_amtEff;
            r_mode <= Mode;
            r_dir  <= Dir;
            r_fill <= ShiftIn[WIDTH-1];
         end else if (r_state == ST_SHIFT) begin
            r_work <= w_stepOut;
            r_rem  <= w_remNext;
         end
      end
   end

   assign Busy       = (r_state == ST_SHIFT);
   assign Done       = (r_state == ST_DONE);
   assign ShifterOut = r_work;

   // The extenders are pure wiring on Imm.  Reset does not affect them.
   assign ZeroExtOut = WIDTH'(Imm);
   assign SignExtOut = {{(WIDTH - IMM_WIDTH){Imm[IMM_WIDTH-1]}}, Imm};

endmodule

// File: tb/tb_shift_ext_unit_seq.sv
// tb_shift_ext_unit_seq
// Directed bench for shift_ext_unit_seq with WIDTH=16, IMM_WIDTH=12, STEP=4.
// The rotate expectations follow SHIFT_EXT_ROTATE_EN, so the bench matches
// whichever build of the design it is compiled with.
module tb_shift_ext_unit_seq;

   logic        CLK;
   logic        RST;
   logic        Start;
   logic [15:0] ShiftIn;
   logic [11:0] Imm;
   logic [1:0]  Mode;
   logic        Dir;
   logic        Busy;
   logic        Done;
   logic [15:0] ShifterOut;
   logic [15:0] ZeroExtOut;
   logic [15:0] SignExtOut;

   int testsRun  = 0;
   int failCount = 0;

   shift_ext_unit_seq #(
      .WIDTH     (16),
      .IMM_WIDTH (12),
      .STEP      (4)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .Start      (Start),
      .ShiftIn    (ShiftIn),
      .Imm        (Imm),
      .Mode       (Mode),
      .Dir        (Dir),
      .Busy       (Busy),
      .Done       (Done),
      .ShifterOut (ShifterOut),
      .ZeroExtOut (ZeroExtOut),
      .SignExtOut (SignExtOut)
   );

   // 10-unit clock period
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Advance one rising edge, then settle so outputs are read away from the edge
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One comparison: count it, and on a miss count and report it
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Issue one operation and follow it to Done.  Inputs are scrambled right
   // after acceptance; the result must not depend on them.
   task automatic applyStimulus(input string tag, input logic [15:0] si,
                                input logic [11:0] imm, input logic [1:0] md,
                                input logic dr, input int expBusy,
                                input logic [15:0] expOut);
      int busyCycles = 0;
      ShiftIn = si;
      Imm     = imm;
      Mode    = md;
      Dir     = dr;
      Start   = 1'b1;
      tick();
      Start   = 1'b0;
      ShiftIn = ~si;
      Imm     = imm + 12'd1;
      Mode    = ~md;
      Dir     = ~dr;
      while (Busy === 1'b1 && busyCycles < 40) begin
         busyCycles++;
         tick();
      end
      checkOutput({tag, ".busyCycles"}, busyCycles, expBusy);
      checkOutput({tag, ".done"}, {31'd0, Done}, 32'd1);
      checkOutput({tag, ".out"}, {16'd0, ShifterOut}, {16'd0, expOut});
   endtask

   // Safety net in case the handshake locks up somewhere unexpected
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not reach the summary");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int doneSeen;

      // Reset with Start held high: reset must win
      RST     = 1'b1;
      Start   = 1'b1;
      ShiftIn = 16'h8001;
      Imm     = 12'h800;
      Mode    = 2'b00;
      Dir     = 1'b0;
      tick();
      tick();
      checkOutput("reset.busy", {31'd0, Busy}, 32'd0);
      checkOutput("reset.done", {31'd0, Done}, 32'd0);
      checkOutput("reset.out", {16'd0, ShifterOut}, 32'h0000);
      checkOutput("reset.zext800", {16'd0, ZeroExtOut}, 32'h0800);
      checkOutput("reset.sext800", {16'd0, SignExtOut}, 32'hF800);
      Start = 1'b0;
      tick();
      RST = 1'b0;
      Imm = 12'h7FF;
      #1;
      checkOutput("ext.zext7FF", {16'd0, ZeroExtOut}, 32'h07FF);
      checkOutput("ext.sext7FF", {16'd0, SignExtOut}, 32'h07FF);
      Imm = 12'hA5C;
      #1;
      checkOutput("ext.zextA5C", {16'd0, ZeroExtOut}, 32'h0A5C);
      checkOutput("ext.sextA5C", {16'd0, SignExtOut}, 32'hFA5C);
      tick();

      // Basic shifts
      applyStimulus("t1.lsl4", 16'h8001, 12'h004, 2'b00, 1'b0, 1, 16'h0010);
      tick();
      applyStimulus("t2.asr5", 16'h8000, 12'd5, 2'b01, 1'b1, 2, 16'hFC00);
      tick();
      applyStimulus("t2.lsr5", 16'h8000, 12'd5, 2'b00, 1'b1, 2, 16'h0400);
      tick();
      applyStimulus("t2.asl1", 16'h8001, 12'd1, 2'b01, 1'b0, 1, 16'h0002);
      tick();
      applyStimulus("t2.mode11", 16'h8000, 12'd3, 2'b11, 1'b1, 1, 16'h1000);
      tick();

      // Saturating amounts
      applyStimulus("t3.lsrSat", 16'hFFFF, 12'h0FF, 2'b00, 1'b1, 4, 16'h0000);
      tick();
      applyStimulus("t3.asrSat", 16'h8000, 12'h0FF, 2'b01, 1'b1, 4, 16'hFFFF);
      tick();
      applyStimulus("t3.lsl16", 16'h1234, 12'd16, 2'b00, 1'b0, 4, 16'h0000);
      tick();

      // Start pulsed throughout a 3-cycle op: only one operation, one Done
      ShiftIn = 16'hF000;
      Imm     = 12'd12;
      Mode    = 2'b00;
      Dir     = 1'b1;
      Start   = 1'b1;
      tick();
      checkOutput("t4.busy1", {31'd0, Busy}, 32'd1);
      ShiftIn = 16'hFFFF;
      Imm     = 12'd1;
      Mode    = 2'b01;
      Dir     = 1'b0;
      tick();
      checkOutput("t4.busy2", {31'd0, Busy}, 32'd1);
      Start = 1'b0;
      tick();
      checkOutput("t4.busy3", {31'd0, Busy}, 32'd1);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      checkOutput("t4.done", {31'd0, Done}, 32'd1);
      checkOutput("t4.out", {16'd0, ShifterOut}, 32'h000F);
      tick();
      checkOutput("t4.doneOnce", {31'd0, Done}, 32'd0);
      checkOutput("t4.idle", {31'd0, Busy}, 32'd0);
      checkOutput("t4.held", {16'd0, ShifterOut}, 32'h000F);

      // Back-to-back: the second request is issued in the DONE cycle of the first
      applyStimulus("t4.b2bA", 16'h0001, 12'd1, 2'b00, 1'b0, 1, 16'h0002);
      applyStimulus("t4.b2bB", 16'h0100, 12'd8, 2'b00, 1'b1, 2, 16'h0001);
      tick();

      // Zero amount still takes one shift cycle and returns the operand
      applyStimulus("t4.imm0", 16'hA5C3, 12'd0, 2'b01, 1'b1, 1, 16'hA5C3);
      tick();

      // Reset in the 2nd SHIFT cycle of a 4-cycle op aborts it
      ShiftIn = 16'hFFFF;
      Imm     = 12'd16;
      Mode    = 2'b00;
      Dir     = 1'b1;
      Start   = 1'b1;
      tick();
      Start = 1'b0;
      tick();
      checkOutput("t5.midBusy", {31'd0, Busy}, 32'd1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      checkOutput("t5.busy", {31'd0, Busy}, 32'd0);
      checkOutput("t5.done", {31'd0, Done}, 32'd0);
      checkOutput("t5.out", {16'd0, ShifterOut}, 32'h0000);
      doneSeen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         doneSeen += int'(Done);
      end
      checkOutput("t5.noLateDone", doneSeen, 0);

      // Mode 10: rotate when built in, saturating logical otherwise
`ifdef SHIFT_EXT_ROTATE_EN
      applyStimulus("t6.rot", 16'h8001, 12'd17, 2'b10, 1'b0, 1, 16'h0003);
      tick();
      applyStimulus("t6.rorSmall", 16'h0001, 12'd4, 2'b10, 1'b1, 1, 16'h1000);
`else
      applyStimulus("t6.rot", 16'h8001, 12'd17, 2'b10, 1'b0, 4, 16'h0000);
      tick();
      applyStimulus("t6.rorSmall", 16'h0001, 12'd4, 2'b10, 1'b1, 1, 16'h0000);
`endif
      tick();

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
